// File: rtl/axi2mem_wr_channel.sv
// AXI4 slave write channel of the axi2mem bridge: splits each 64-bit W beat into
// two 32-bit TCDM write commands and returns one posted, in-order B per burst.
module axi2mem_wr_channel #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int B_DEPTH        = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        axi_slave_aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr_i,
  input  logic [2:0]                  axi_slave_aw_prot_i,
  input  logic [3:0]                  axi_slave_aw_region_i,
  input  logic [7:0]                  axi_slave_aw_len_i,
  input  logic [2:0]                  axi_slave_aw_size_i,
  input  logic [1:0]                  axi_slave_aw_burst_i,
  input  logic                        axi_slave_aw_lock_i,
  input  logic [3:0]                  axi_slave_aw_cache_i,
  input  logic [3:0]                  axi_slave_aw_qos_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user_i,
  output logic                        axi_slave_aw_ready_o,
  input  logic                        axi_slave_w_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user_i,
  input  logic                        axi_slave_w_last_i,
  output logic                        axi_slave_w_ready_o,
  output logic                        axi_slave_b_valid_o,
  output logic [1:0]                  axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user_o,
  input  logic                        axi_slave_b_ready_i,
  output logic [1:0][5:0]             trans_id_o,
  output logic [1:0][31:0]            trans_add_o,
  output logic [1:0][31:0]            trans_wdata_o,
  output logic [1:0][3:0]             trans_be_o,
  output logic [1:0]                  trans_req_o,
  output logic [1:0]                  trans_last_o,
  input  logic [1:0]                  trans_gnt_i
);

  localparam int PW = $clog2(B_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_reg, state_next;
  logic [7:0]              len_reg;
  logic [7:0]              count_reg;
  logic [31:0]             addr_reg;
  logic [AXI_ID_WIDTH-1:0] id_reg;
  logic [31:0]             beat_addr;

  logic [AXI_ID_WIDTH-1:0] b_mem [B_DEPTH];
  logic [PW-1:0]           b_wptr_reg, b_rptr_reg;
  logic [PW:0]             b_cnt_reg;
  logic                    b_full, b_push, b_pop;

  logic aw_hs, w_hs, last_beat;
  logic unused_inputs;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (aw_hs) state_next = RUN;
      RUN:     if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; aw_ready is also masked by reset so every output reads 0 during it
  always_comb begin
    axi_slave_aw_ready_o = 1'b0;
    axi_slave_w_ready_o  = 1'b0;
    case (state_reg)
      IDLE:    axi_slave_aw_ready_o = ~b_full & ~rst_i;
      RUN:     axi_slave_w_ready_o  = (trans_gnt_i == 2'b11);
      default: ;
    endcase
  end

  assign aw_hs     = axi_slave_aw_valid_i & axi_slave_aw_ready_o;
  assign w_hs      = axi_slave_w_valid_i & axi_slave_w_ready_o;
  assign last_beat = w_hs & (count_reg == len_reg);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_reg   <= '0;
      count_reg <= '0;
      addr_reg  <= '0;
      id_reg    <= '0;
    end else if (aw_hs) begin
      len_reg   <= axi_slave_aw_len_i;
      count_reg <= '0;
      addr_reg  <= {axi_slave_aw_addr_i[31:3], 3'b000};
      id_reg    <= axi_slave_aw_id_i;
    end else if (w_hs) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  // Every beat is 8 bytes INCR regardless of the AW size/burst fields
  assign beat_addr = addr_reg + {21'd0, count_reg, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign trans_req_o[gi]   = w_hs;
      assign trans_last_o[gi]  = last_beat;
      assign trans_id_o[gi]    = w_hs ? 6'(id_reg) : 6'd0;
      assign trans_add_o[gi]   = w_hs ? beat_addr + 32'(gi * 4) : 32'd0;
      assign trans_wdata_o[gi] = w_hs ? axi_slave_w_data_i[gi*32 +: 32] : 32'd0;
      assign trans_be_o[gi]    = w_hs ? axi_slave_w_strb_i[gi*4 +: 4] : 4'd0;
    end
  endgenerate

  // Posted B queue: an AW is only taken while a slot is free, so a push never overflows
  assign b_full              = (b_cnt_reg == (PW+1)'(B_DEPTH));
  assign b_push              = last_beat;
  assign axi_slave_b_valid_o = (b_cnt_reg != '0);
  assign b_pop               = axi_slave_b_valid_o & axi_slave_b_ready_i;

  always_ff @(posedge clk_i) begin
    if (b_push) b_mem[b_wptr_reg] <= id_reg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_wptr_reg <= '0;
      b_rptr_reg <= '0;
      b_cnt_reg  <= '0;
    end else begin
      if (b_push) b_wptr_reg <= b_wptr_reg + 1'b1;
      if (b_pop)  b_rptr_reg <= b_rptr_reg + 1'b1;
      case ({b_push, b_pop})
        2'b10:   b_cnt_reg <= b_cnt_reg + 1'b1;
        2'b01:   b_cnt_reg <= b_cnt_reg - 1'b1;
        default: b_cnt_reg <= b_cnt_reg;
      endcase
    end
  end

  assign axi_slave_b_id_o   = axi_slave_b_valid_o ? b_mem[b_rptr_reg] : '0;
  assign axi_slave_b_resp_o = 2'b00;
  assign axi_slave_b_user_o = '0;

  assign unused_inputs = ^{axi_slave_aw_addr_i, axi_slave_aw_prot_i, axi_slave_aw_region_i,
                           axi_slave_aw_size_i, axi_slave_aw_burst_i, axi_slave_aw_lock_i,
                           axi_slave_aw_cache_i, axi_slave_aw_qos_i, axi_slave_aw_user_i,
                           axi_slave_w_user_i, axi_slave_w_last_i, axi_slave_w_data_i,
                           axi_slave_w_strb_i};

endmodule

// File: tb/tb_axi2mem_wr_channel.sv
// Directed bench for axi2mem_wr_channel: table of single-beat bursts plus
// hand-written burst, stall, B back-pressure and reset sequences.
module tb_axi2mem_wr_channel;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             aw_valid = 1'b0;
  logic [31:0]      aw_addr = '0;
  logic [7:0]       aw_len = '0;
  logic [2:0]       aw_id = '0;
  logic             aw_ready;
  logic             w_valid = 1'b0;
  logic [63:0]      w_data = '0;
  logic [7:0]       w_strb = '0;
  logic             w_last = 1'b0;
  logic             w_ready;
  logic             b_valid;
  logic [1:0]       b_resp;
  logic [2:0]       b_id;
  logic [5:0]       b_user;
  logic             b_ready = 1'b1;
  logic [1:0][5:0]  trans_id;
  logic [1:0][31:0] trans_add;
  logic [1:0][31:0] trans_wdata;
  logic [1:0][3:0]  trans_be;
  logic [1:0]       trans_req;
  logic [1:0]       trans_last;
  logic [1:0]       gnt = 2'b11;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  id;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [31:0] add0, add1, wd0, wd1;
    logic [3:0]  be0, be1;
  } vec_t;

  typedef struct {
    logic [1:0]  req, last;
    logic [31:0] add0, add1, wd0, wd1;
    logic [3:0]  be0, be1;
    logic [5:0]  tid0, tid1;
    logic        aw_rdy;
  } cmd_t;

  vec_t vecs[4];

  axi2mem_wr_channel dut (
    .clk_i(clk), .rst_i(rst),
    .axi_slave_aw_valid_i(aw_valid), .axi_slave_aw_addr_i(aw_addr),
    .axi_slave_aw_prot_i(3'd0), .axi_slave_aw_region_i(4'd0),
    .axi_slave_aw_len_i(aw_len), .axi_slave_aw_size_i(3'd3),
    .axi_slave_aw_burst_i(2'd1), .axi_slave_aw_lock_i(1'b0),
    .axi_slave_aw_cache_i(4'd0), .axi_slave_aw_qos_i(4'd0),
    .axi_slave_aw_id_i(aw_id), .axi_slave_aw_user_i(6'd0),
    .axi_slave_aw_ready_o(aw_ready),
    .axi_slave_w_valid_i(w_valid), .axi_slave_w_data_i(w_data),
    .axi_slave_w_strb_i(w_strb), .axi_slave_w_user_i(6'd0),
    .axi_slave_w_last_i(w_last), .axi_slave_w_ready_o(w_ready),
    .axi_slave_b_valid_o(b_valid), .axi_slave_b_resp_o(b_resp),
    .axi_slave_b_id_o(b_id), .axi_slave_b_user_o(b_user),
    .axi_slave_b_ready_i(b_ready),
    .trans_id_o(trans_id), .trans_add_o(trans_add), .trans_wdata_o(trans_wdata),
    .trans_be_o(trans_be), .trans_req_o(trans_req), .trans_last_o(trans_last),
    .trans_gnt_i(gnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the AW handshake
  task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] id);
    int k;
    aw_valid = 1'b1; aw_addr = a; aw_len = l; aw_id = id;
    #3;
    k = 0;
    while (!aw_ready && k < 20) begin @(posedge clk); #3; k++; end
    check("aw_wait", (k < 20) ? 1 : 0, 1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    $display("AW addr=%08h len=%0d id=%0d", a, l, id);
  endtask

  // Called at posedge+1; captures the command outputs of the handshake cycle
  task automatic send_w(input logic [63:0] d, input logic [7:0] s, output cmd_t c);
    int k;
    w_valid = 1'b1; w_data = d; w_strb = s;
    #3;
    k = 0;
    while (!w_ready && k < 20) begin @(posedge clk); #3; k++; end
    check("w_wait", (k < 20) ? 1 : 0, 1);
    c.req = trans_req; c.last = trans_last;
    c.add0 = trans_add[0]; c.add1 = trans_add[1];
    c.wd0 = trans_wdata[0]; c.wd1 = trans_wdata[1];
    c.be0 = trans_be[0]; c.be1 = trans_be[1];
    c.tid0 = trans_id[0]; c.tid1 = trans_id[1];
    c.aw_rdy = aw_ready;
    @(posedge clk); #1;
    w_valid = 1'b0;
    $display("W data=%016h strb=%02h -> req=%b last=%b add0=%08h add1=%08h",
             d, s, c.req, c.last, c.add0, c.add1);
  endtask

  initial begin
    cmd_t c;
    logic [2:0] exp_ids [4];

    vecs[0] = '{32'h0000_1004, 3'd5, 64'h1122_3344_5566_7788, 8'hFF,
                32'h0000_1000, 32'h0000_1004, 32'h5566_7788, 32'h1122_3344, 4'hF, 4'hF};
    vecs[1] = '{32'h0000_300F, 3'd2, 64'hDEAD_BEEF_CAFE_F00D, 8'hA5,
                32'h0000_3008, 32'h0000_300C, 32'hCAFE_F00D, 32'hDEAD_BEEF, 4'h5, 4'hA};
    vecs[2] = '{32'hFFFF_FFFC, 3'd7, 64'h0123_4567_89AB_CDEF, 8'h0F,
                32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h89AB_CDEF, 32'h0123_4567, 4'hF, 4'h0};
    vecs[3] = '{32'h0000_0000, 3'd0, 64'h0, 8'h00,
                32'h0, 32'h4, 32'h0, 32'h0, 4'h0, 4'h0};

    // Reset state
    #2;
    check("rst_aw_ready", aw_ready, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_req", trans_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("idle_aw_ready", aw_ready, 1);
    @(posedge clk); #1;

    // Single-beat bursts from the table
    for (int i = 0; i < 4; i++) begin
      send_aw(vecs[i].addr, 8'd0, vecs[i].id);
      send_w(vecs[i].data, vecs[i].strb, c);
      check($sformatf("v%0d_aw_ready_run", i), c.aw_rdy, 0);
      check($sformatf("v%0d_req", i), c.req, 2'b11);
      check($sformatf("v%0d_last", i), c.last, 2'b11);
      check($sformatf("v%0d_add0", i), c.add0, vecs[i].add0);
      check($sformatf("v%0d_add1", i), c.add1, vecs[i].add1);
      check($sformatf("v%0d_wdata0", i), c.wd0, vecs[i].wd0);
      check($sformatf("v%0d_wdata1", i), c.wd1, vecs[i].wd1);
      check($sformatf("v%0d_be0", i), c.be0, vecs[i].be0);
      check($sformatf("v%0d_be1", i), c.be1, vecs[i].be1);
      check($sformatf("v%0d_tid0", i), c.tid0, {3'd0, vecs[i].id});
      check($sformatf("v%0d_tid1", i), c.tid1, {3'd0, vecs[i].id});
      check($sformatf("v%0d_b_valid", i), b_valid, 1);
      check($sformatf("v%0d_b_id", i), b_id, vecs[i].id);
      check($sformatf("v%0d_b_resp", i), b_resp, 0);
      check($sformatf("v%0d_b_user", i), b_user, 0);
    end

    // Four-beat burst: addresses step by 8, last only on the final beat, one B
    send_aw(32'h0000_2000, 8'd3, 3'd3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_b_idle%0d", i), b_valid, 0);
      send_w(64'h1000 + 64'(i), 8'hFF, c);
      check($sformatf("burst_add0_%0d", i), c.add0, 32'h2000 + 32'(8 * i));
      check($sformatf("burst_last_%0d", i), c.last, (i == 3) ? 2'b11 : 2'b00);
    end
    check("burst_b_valid", b_valid, 1);
    check("burst_b_id", b_id, 3);
    @(posedge clk); #1;
    check("burst_single_b", b_valid, 0);

    // Grant stall mid-burst
    send_aw(32'h0000_4000, 8'd3, 3'd1);
    send_w(64'hA0, 8'hFF, c);
    check("stall_add0_b0", c.add0, 32'h4000);
    send_w(64'hA1, 8'hFF, c);
    check("stall_add0_b1", c.add0, 32'h4008);
    w_valid = 1'b1; gnt = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("stall_w_ready%0d", i), w_ready, 0);
      check($sformatf("stall_req%0d", i), trans_req, 0);
      $display("STALL cycle %0d gnt=%b w_ready=%b req=%b", i, gnt, w_ready, trans_req);
      @(posedge clk); #1;
    end
    gnt = 2'b11; w_valid = 1'b0;
    send_w(64'hA2, 8'hFF, c);
    check("stall_add0_b2", c.add0, 32'h4010);
    check("stall_last_b2", c.last, 0);
    send_w(64'hA3, 8'hFF, c);
    check("stall_add0_b3", c.add0, 32'h4018);
    check("stall_last_b3", c.last, 2'b11);
    check("stall_b_id", b_id, 1);

    // Address wrap across the 32-bit boundary
    send_aw(32'hFFFF_FFF8, 8'd1, 3'd4);
    send_w(64'hB0, 8'hFF, c);
    check("wrap_add1_b0", c.add1, 32'hFFFF_FFFC);
    send_w(64'hB1, 8'hFF, c);
    check("wrap_add0_b1", c.add0, 32'h0000_0000);
    check("wrap_add1_b1", c.add1, 32'h0000_0004);
    @(posedge clk); #1;

    // B back-pressure: four pending responses block a fifth AW
    b_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_aw(32'h100 * (i + 1), 8'd0, 3'(i));
      send_w(64'(i), 8'hFF, c);
    end
    check("bp_b_valid", b_valid, 1);
    check("bp_b_head", b_id, 0);
    check("bp_aw_blocked0", aw_ready, 0);
    aw_valid = 1'b1; aw_addr = 32'h5000; aw_len = 8'd0; aw_id = 3'd6;
    @(posedge clk); #1;
    check("bp_aw_blocked1", aw_ready, 0);
    b_ready = 1'b1;
    #3;
    check("bp_aw_blocked2", aw_ready, 0);
    @(posedge clk); #1;
    b_ready = 1'b0;
    check("bp_aw_after_pop", aw_ready, 1);
    check("bp_b_head_after_pop", b_id, 1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    $display("AW addr=00005000 len=0 id=6 (after pop)");
    send_w(64'h55, 8'hFF, c);
    check("bp_fifth_add0", c.add0, 32'h5000);
    exp_ids[0] = 3'd1; exp_ids[1] = 3'd2; exp_ids[2] = 3'd3; exp_ids[3] = 3'd6;
    b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_drain_valid%0d", i), b_valid, 1);
      check($sformatf("bp_drain_id%0d", i), b_id, exp_ids[i]);
      $display("B id=%0d resp=%0d", b_id, b_resp);
      @(posedge clk); #1;
    end
    check("bp_drained", b_valid, 0);

    // Reset mid-burst with a B pending
    b_ready = 1'b0;
    send_aw(32'h6000, 8'd0, 3'd7);
    send_w(64'h60, 8'hFF, c);
    send_aw(32'h6100, 8'd3, 3'd2);
    send_w(64'h61, 8'hFF, c);
    send_w(64'h62, 8'hFF, c);
    w_valid = 1'b1;
    #1;
    check("pre_rst_req", trans_req, 2'b11);
    rst = 1'b1;
    #1;
    check("mid_rst_b_valid", b_valid, 0);
    check("mid_rst_aw_ready", aw_ready, 0);
    check("mid_rst_req", trans_req, 0);
    check("mid_rst_w_ready", w_ready, 0);
    $display("RESET asserted mid-burst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
    send_aw(32'h7000, 8'd0, 3'd5);
    send_w(64'h70, 8'h3C, c);
    check("post_rst_add0", c.add0, 32'h7000);
    check("post_rst_last", c.last, 2'b11);
    check("post_rst_be0", c.be0, 4'hC);
    check("post_rst_be1", c.be1, 4'h3);
    check("post_rst_b_valid", b_valid, 1);
    check("post_rst_b_id", b_id, 5);
    @(posedge clk); #1;
    check("post_rst_single_b", b_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi2mem_wr_channel.md
Name: axi2mem_wr_channel

Overview:
AXI4 slave write-channel front end of the axi2mem bridge, the write-direction counterpart of the read channel. It accepts AW bursts and W beats, splits each 64-bit W beat into two 32-bit memory write commands, and issues them on the dual-port TCDM command interface (port 0 = low word, port 1 = high word). It returns one posted OKAY B response per burst, in order, with the burst's AXI ID.

Parameters:
AXI_ADDR_WIDTH, 32, AW address width (>=32)
AXI_DATA_WIDTH, 64, W data width; only 64 supported
AXI_USER_WIDTH, 6, user field width
AXI_ID_WIDTH, 3, AXI ID width (<=6)
B_DEPTH, 4, pending B responses (power of 2, >=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
axi_slave_aw_valid_i  in  1  AW valid
axi_slave_aw_addr_i  in  AXI_ADDR_WIDTH  start address
axi_slave_aw_prot_i/region_i/cache_i/qos_i/lock_i/size_i/burst_i  in  3/4/4/4/1/3/2  ignored
axi_slave_aw_len_i  in  8  beats-1
axi_slave_aw_id_i  in  AXI_ID_WIDTH  burst ID
axi_slave_aw_user_i  in  AXI_USER_WIDTH  ignored
axi_slave_aw_ready_o  out  1  AW ready
axi_slave_w_valid_i  in  1  W valid
axi_slave_w_data_i  in  64  write data
axi_slave_w_strb_i  in  8  byte strobes
axi_slave_w_last_i  in  1  ignored for sequencing
axi_slave_w_user_i  in  AXI_USER_WIDTH  ignored
axi_slave_w_ready_o  out  1  W ready
axi_slave_b_valid_o  out  1  B valid
axi_slave_b_resp_o  out  2  always 2'b00
axi_slave_b_id_o  out  AXI_ID_WIDTH  head-of-queue ID
axi_slave_b_user_o  out  AXI_USER_WIDTH  always 0
axi_slave_b_ready_i  in  1  B ready
trans_id_o  out  2x6  zero-extended burst ID, both ports
trans_add_o  out  2x32  word address per port
trans_wdata_o  out  2x32  port0 = data[31:0], port1 = data[63:32]
trans_be_o  out  2x4  port0 = strb[3:0], port1 = strb[7:4]
trans_req_o  out  2  command request
trans_last_o  out  2  last command of burst
trans_gnt_i  in  2  command queue can accept (level, sampled same cycle)

Behaviour:
- Reset (rst_i high, async): FSM to IDLE; beat counter, latched len/addr/id = 0; B queue emptied. All outputs 0.
- FSM states IDLE and RUN.
- IDLE: aw_ready_o = 1 iff B queue occupancy < B_DEPTH. On AW handshake, latch:
  - len
  - addr with [2:0] forced to 0
  - id
  - beat counter cleared
  Go to RUN next cycle. w_ready_o = 0 in IDLE; AW and the first W beat are never accepted in the same cycle.
- RUN:
  - aw_ready_o = 0.
  - w_ready_o = 1 iff trans_gnt_i == 2'b11; W handshake = w_valid_i & w_ready_o.
  - On a W handshake (same cycle, combinational): trans_req_o = 2'b11; trans_add_o[0] = base + (count << 3); trans_add_o[1] = trans_add_o[0] + 4 (32-bit wrap); wdata/be split as per Ports.
  - Otherwise all trans_* outputs = 0.
  - Beat counter is 8 bits and increments per handshake.
- Last beat (count == latched len): trans_last_o = 2'b11; push latched ID into B queue; go to IDLE next cycle. len = 0 yields a single beat.
- w_last_i is not checked. Burst type and size are ignored; every burst is treated as INCR, 8 bytes/beat.
- B queue: FIFO of depth B_DEPTH.
  - b_valid_o = not empty; b_id_o = head entry.
  - Pop on b_valid_o & b_ready_i.
  - Push and pop in the same cycle are both performed; occupancy unchanged.
  - B may be issued in the cycle after the last-beat command; no wait for memory completion (posted).
- Latency: AW handshake at cycle t, first command at t+1 at the earliest. Last command at t, b_valid_o at t+1 (if queue was empty).
- Back-pressure: gnt deasserted mid-burst stalls W with no command issued and state held. B queue full in IDLE blocks AW only.
- Reset mid-burst: in-flight burst and pending B responses are discarded; the next AW restarts cleanly.

Test Plan:
- Single beat: AW addr=0x1004, len=0, id=5; W data=0x11223344_55667788, strb=0xFF -> one cycle req=11, add0=0x1000, add1=0x1004, wdata0=0x55667788, wdata1=0x11223344, last=11; B id=5, resp=0 next cycle.
- Burst: len=3, addr=0x2000, gnt=11 throughout -> 4 command cycles, add0 = 0x2000/0x2008/0x2010/0x2018; last only on the 4th; exactly one B.
- Stall: gnt=01 for 3 cycles mid-burst -> w_ready=0, req=00, counter held; resumes at the correct address.
- Strobe split: strb=0xA5 -> be0=0x5, be1=0xA.
- B back-pressure: b_ready=0 and 4 single-beat bursts complete -> 5th AW not accepted (aw_ready=0); one B pop -> AW accepted next cycle; IDs returned in issue order.
- Async reset asserted mid-burst (2 of 4 beats done) -> immediately b_valid=0, aw_ready=0, req=00; after release a new AW len=0 completes normally with a single B.
